// File: rtl/pulse_pkg.sv
// pulse_pkg: state encoding and default sizing shared by the pulse link blocks
package pulse_pkg;

    typedef enum logic [1:0] {IDLE, HIGH, GAP} state_e;

    localparam int DEFAULT_WIDTH   = 8;
    localparam int DEFAULT_MIN_GAP = 2;

endpackage

// File: rtl/pulse_down_counter.sv
// pulse_down_counter: loadable down-counter that parks at zero and flags it
module pulse_down_counter
    import pulse_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    // load wins over decrement; decrement stops at zero so it can never wrap
    always_comb begin
        cnt_d = load_i ? load_val_i : (dec_i && cnt_q != '0) ? cnt_q - WIDTH'(1) : cnt_q;
    end

    // count register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign zero_o = cnt_q == '0;

endmodule

// File: rtl/pulse_generator.sv
// pulse_generator: emits one high pulse of the requested length with an enforced low gap
module pulse_generator
    import pulse_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int MIN_GAP = DEFAULT_MIN_GAP
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cfg_valid_i,
    output logic             cfg_ready_o,
    input  logic [WIDTH-1:0] cfg_duration_i,
    input  logic             abort_i,
    output logic             signal_out_o,
    output logic             busy_o,
    output logic             done_o
);

    // counters are loaded with length-1 so their zero flag marks the last cycle
    localparam logic [WIDTH-1:0] GAP_LOAD = WIDTH'(MIN_GAP - 1);

    state_e           state_q;
    logic             sig_q, done_q, pend_q;
    logic [WIDTH-1:0] pend_dur_q;
    logic             xfer, req_v, pop, len_load, len_last, gap_load, gap_last;
    logic [WIDTH-1:0] req_dur;

    // handshake, and an idle FSM takes a request straight off the bus when the slot is empty
    always_comb begin
        cfg_ready_o = !pend_q && !abort_i;
        xfer        = cfg_valid_i && cfg_ready_o;
        req_v       = pend_q || xfer;
        req_dur     = pend_q ? pend_dur_q : cfg_duration_i;
        pop         = state_q == IDLE && req_v && !abort_i;
        len_load    = pop && req_dur != '0;
        gap_load    = (state_q == HIGH && (abort_i || len_last)) || (state_q == GAP && abort_i);
    end

    pulse_down_counter #(.WIDTH(WIDTH)) u_len (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (len_load),
        .load_val_i (req_dur - WIDTH'(1)),
        .dec_i      (state_q == HIGH),
        .zero_o     (len_last)
    );

    pulse_down_counter #(.WIDTH(WIDTH)) u_gap (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (gap_load),
        .load_val_i (GAP_LOAD),
        .dec_i      (state_q == GAP),
        .zero_o     (gap_last)
    );

    // sequencing FSM with pending slot; outputs are registered alongside the state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            sig_q      <= 1'b0;
            done_q     <= 1'b0;
            pend_q     <= 1'b0;
            pend_dur_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (abort_i || pop) begin
                pend_q <= 1'b0;
            end else if (xfer) begin
                pend_q     <= 1'b1;
                pend_dur_q <= cfg_duration_i;
            end
            case (state_q)
                IDLE: begin
                    if (pop && req_dur != '0) begin
                        state_q <= HIGH;
                        sig_q   <= 1'b1;
                    end else if (pop) begin
                        done_q <= 1'b1;
                    end
                end
                HIGH: begin
                    if (abort_i || len_last) begin
                        state_q <= GAP;
                        sig_q   <= 1'b0;
                        done_q  <= !abort_i;
                    end
                end
                GAP: begin
                    if (!abort_i && gap_last) state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    sig_q   <= 1'b0;
                end
            endcase
        end
    end

    assign signal_out_o = sig_q;
    assign done_o       = done_q;
    assign busy_o       = state_q != IDLE || pend_q;

endmodule

// File: tb/tb_pulse_generator.sv
// tb_pulse_generator: directed and random checks of pulse lengths, gaps and done strobes
module tb_pulse_generator;

    localparam int MIN_GAP = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [7:0] cfg_duration = '0;
    logic       abort = 1'b0;
    logic       sig, busy, done;

    int n_chk = 0;
    int n_fail = 0;
    int n_done = 0;
    int widths[$];
    int gaps[$];
    int exp_w[$];
    int run = 0;
    int low = 0;
    bit prev = 0;
    bit seen = 0;

    always #5 clk = ~clk;

    pulse_generator #(.WIDTH(8), .MIN_GAP(MIN_GAP)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .cfg_valid_i    (cfg_valid),
        .cfg_ready_o    (cfg_ready),
        .cfg_duration_i (cfg_duration),
        .abort_i        (abort),
        .signal_out_o   (sig),
        .busy_o         (busy),
        .done_o         (done)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // trace monitor: measures high runs, low runs between pulses and done strobes
    always @(negedge clk) begin
        if (!rst_n) begin
            run = 0; low = 0; prev = 0; seen = 0;
        end else begin
            if (done) begin
                n_done++;
                chk("done_with_high", int'(sig), 0);
            end
            if (sig) begin
                if (!prev && seen) gaps.push_back(low);
                run++;
            end else begin
                if (prev) begin
                    widths.push_back(run);
                    run = 0; low = 0; seen = 1;
                end
                low++;
            end
            prev = sig;
        end
    end

    task automatic clr();
        widths.delete(); gaps.delete(); exp_w.delete();
        n_done = 0; seen = 0;
    endtask

    task automatic send(input int d);
        int n = 0;
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_duration = 8'(d);
        while (!cfg_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("send_timeout", n, 0);
        @(posedge clk);
        #1 cfg_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("idle_timeout", n, 0);
    endtask

    task automatic chk_pulses(input string tag);
        chk({tag, "_count"}, widths.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < widths.size(); i++) chk({tag, "_width"}, widths[i], exp_w[i]);
    endtask

    initial begin
        int d;
        int n_req;
        repeat (3) @(negedge clk);
        chk("rst_sig", int'(sig), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", int'(cfg_ready), 1);

        // single pulse of 5 from idle
        clr();
        send(5);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk($sformatf("d5_sig_c%0d", k), int'(sig), int'(k <= 5));
            chk($sformatf("d5_done_c%0d", k), int'(done), int'(k == 6));
            chk($sformatf("d5_busy_c%0d", k), int'(busy), int'(k < 6 + MIN_GAP));
        end

        // back-to-back 3 then 7
        clr();
        send(3);
        send(7);
        wait_idle();
        exp_w = '{3, 7};
        chk_pulses("b2b");
        chk("b2b_gaps", gaps.size(), 1);
        if (gaps.size() > 0) chk("b2b_gap_len", gaps[0], MIN_GAP + 1);
        chk("b2b_done", n_done, 2);

        // null request
        clr();
        send(0);
        @(negedge clk);
        chk("d0_done", int'(done), 1);
        chk("d0_sig", int'(sig), 0);
        @(negedge clk);
        chk("d0_done_off", int'(done), 0);
        chk("d0_busy", int'(busy), 0);
        chk("d0_pulses", widths.size(), 0);
        chk("d0_done_cnt", n_done, 1);

        // maximum length
        clr();
        send(255);
        wait_idle();
        exp_w = '{255};
        chk_pulses("d255");
        chk("d255_done", n_done, 1);

        // abort in cycle 2 of a 20-cycle pulse with 4 pending
        clr();
        send(20);
        send(4);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_sig", int'(sig), 0);
        wait_idle();
        repeat (30) @(negedge clk);
        exp_w = '{2};
        chk_pulses("abort");
        chk("abort_done", n_done, 0);

        // abort and valid together: no transfer
        clr();
        @(negedge clk);
        abort = 1'b1;
        cfg_valid = 1'b1;
        cfg_duration = 8'd9;
        #1 chk("abort_ready", int'(cfg_ready), 0);
        @(posedge clk);
        #1 begin abort = 1'b0; cfg_valid = 1'b0; end
        repeat (20) @(negedge clk);
        chk("abortv_pulses", widths.size(), 0);
        chk("abortv_done", n_done, 0);
        chk("abortv_busy", int'(busy), 0);

        // reset in the middle of a pulse
        clr();
        send(10);
        repeat (4) @(negedge clk);
        chk("rmid_sig_pre", int'(sig), 1);
        rst_n = 1'b0;
        #1;
        chk("rmid_sig", int'(sig), 0);
        chk("rmid_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        #1 chk("rmid_ready", int'(cfg_ready), 1);
        repeat (20) @(negedge clk);
        chk("rmid_done", n_done, 0);
        chk("rmid_pulses", widths.size(), 0);

        // loopback-style sequence
        clr();
        send(1); send(2); send(17); send(200);
        wait_idle();
        exp_w = '{1, 2, 17, 200};
        chk_pulses("seq");
        chk("seq_done", n_done, 4);

        // random requests against the trace model
        clr();
        n_req = 0;
        for (int i = 0; i < 30; i++) begin
            d = int'($urandom_range(0, 30));
            if (d != 0) exp_w.push_back(d);
            n_req++;
            send(d);
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end
        wait_idle();
        repeat (4) @(negedge clk);
        chk_pulses("rnd");
        chk("rnd_done", n_done, n_req);
        foreach (gaps[i]) chk("rnd_gap_min", int'(gaps[i] >= MIN_GAP + 1), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
